// File: rtl/char_plot_pkg.sv
// Shared types and geometry for the character-cell rasteriser: cell/pixel widths,
// FSM state encoding and the packed command FIFO entry {CHAR,CY,CX}.
package char_plot_pkg;
    localparam int GLYPH   = 8;
    localparam int CELL_XW = 5;
    localparam int CELL_YW = 4;
    localparam int PIX_XW  = 8;
    localparam int PIX_YW  = 8;
    localparam logic [2:0] LAST = 3'(GLYPH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PIX  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]         chr;
        logic [CELL_YW-1:0] cy;
        logic [CELL_XW-1:0] cx;
    } cmd_t;
endpackage

// File: rtl/char_plot_font_rom.sv
// 1024x8 glyph ROM, address {code[6:0], row}, asynchronous read; bit 7 is the leftmost pixel.
// Holds the subset of the team font used by this block; every other code is blank.
module font_rom (
    input  logic [9:0] addr,
    output logic [7:0] dat
);
    logic [63:0] glyph;
    logic [63:0] shifted;

    always_comb begin
        glyph = 64'h0;
        case (addr[9:3])
            7'h2B:   glyph = 64'h00_18_18_7E_18_18_00_00;
            7'h41:   glyph = 64'h18_3C_66_66_7E_66_66_00;
            7'h48:   glyph = 64'h66_66_66_7E_66_66_66_00;
            7'h49:   glyph = 64'h3C_18_18_18_18_18_3C_00;
            7'h4F:   glyph = 64'h3C_66_66_66_66_66_3C_00;
            default: glyph = 64'h0;
        endcase
        shifted = glyph << {addr[2:0], 3'b000};
        dat     = shifted[63:56];
    end
endmodule

// File: rtl/char_plot.sv
// Expands queued character writes into 64 pixel writes each; first PWE 2 cycles after pop, 73 cycles/glyph.
// CRDY drops when the command FIFO is full; writes while full are silently dropped.
module char_plot
    import char_plot_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter logic [8:0] FG    = 9'h1FF,
    parameter logic [8:0] BG    = 9'h000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CELL_XW-1:0] CX,
    input  logic [CELL_YW-1:0] CY,
    input  logic [7:0]        CHAR,
    input  logic              CWE,
    output logic              CRDY,
    output logic [PIX_XW-1:0] X,
    output logic [PIX_YW-1:0] Y,
    output logic [2:0]        R,
    output logic [2:0]        G,
    output logic [2:0]        B,
    output logic              PWE,
    output logic              BUSY
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    cmd_t               mem [DEPTH];
    cmd_t               head;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count, count_nxt;
    logic               push, pop;
    state_t             state, state_nxt;
    logic [2:0]         row, col;
    logic [CELL_XW-1:0] cur_cx;
    logic [CELL_YW-1:0] cur_cy;
    logic [9:0]         rom_addr;
    logic               hi_code;
    logic [7:0]         rom_dat, glyph, shreg;
    logic [8:0]         rgb;

    font_rom u_rom (
        .addr(rom_addr),
        .dat (rom_dat)
    );

    assign glyph = hi_code ? 8'h00 : rom_dat;
    assign head  = mem[rd_ptr];
    assign push  = CWE & CRDY;
    assign pop   = (state == ST_IDLE) && (count != '0);
    assign R     = rgb[8:6];
    assign G     = rgb[5:3];
    assign B     = rgb[2:0];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pop) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_PIX;
            ST_PIX:  if (col == LAST) state_nxt = (row == LAST) ? ST_IDLE : ST_LOAD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // storage needs no reset: the pointers and count define which entries are live
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= {CHAR, CY, CX};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            CRDY     <= 1'b1;
            BUSY     <= 1'b0;
            row      <= '0;
            col      <= '0;
            cur_cx   <= '0;
            cur_cy   <= '0;
            rom_addr <= '0;
            hi_code  <= 1'b0;
            shreg    <= '0;
            PWE      <= 1'b0;
            X        <= '0;
            Y        <= '0;
            rgb      <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            CRDY  <= (count_nxt != FULL);
            BUSY  <= (count_nxt != '0) || (state_nxt != ST_IDLE);
            PWE   <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        cur_cx   <= head.cx;
                        cur_cy   <= head.cy;
                        hi_code  <= head.chr[7];
                        row      <= '0;
                        rom_addr <= {head.chr[6:0], 3'd0};
                    end
                end
                ST_LOAD: begin
                    // column 0 leaves with this edge; shreg[7] then always holds the next column's bit
                    shreg <= glyph << 1;
                    col   <= '0;
                    PWE   <= 1'b1;
                    X     <= {cur_cx, 3'd0};
                    Y     <= {1'b0, cur_cy, row};
                    rgb   <= glyph[7] ? FG : BG;
                end
                ST_PIX: begin
                    if (col == LAST) begin
                        if (row != LAST) begin
                            row      <= row + 3'd1;
                            rom_addr <= {rom_addr[9:3], row + 3'd1};
                        end
                    end else begin
                        col   <= col + 3'd1;
                        shreg <= shreg << 1;
                        PWE   <= 1'b1;
                        X     <= {cur_cx, col + 3'd1};
                        rgb   <= shreg[7] ? FG : BG;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_char_plot.sv
// Bench for char_plot: a timeline model of the command queue and glyph schedule predicts every
// output each cycle; directed scenarios plus a randomized command stream drive it.
module tb_char_plot;
    localparam int         DEPTH = 4;
    localparam logic [8:0] FG    = 9'h1FF;
    localparam logic [8:0] BG    = 9'h000;

    typedef struct packed {
        logic [7:0] ch;
        logic [3:0] cy;
        logic [4:0] cx;
    } ref_cmd_t;

    logic       CLK, RST, CWE, CRDY, PWE, BUSY;
    logic [4:0] CX;
    logic [3:0] CY;
    logic [7:0] CHAR;
    logic [7:0] X, Y;
    logic [2:0] R, G, B;

    int n_assert = 0;
    int n_fail   = 0;

    ref_cmd_t   cmd_q[$];
    ref_cmd_t   cur;
    bit         act = 0;
    int         pop_edge = 0;
    int         e_now = 0;
    logic       exp_pwe = 0, exp_busy = 0, exp_crdy = 1;
    logic [7:0] exp_x = 0, exp_y = 0;
    logic [8:0] exp_rgb = 0;
    int         pwe_cnt = 0, glyph_cnt = 0, low_run = 2;
    int         start_q[$];

    char_plot #(.DEPTH(DEPTH), .FG(FG), .BG(BG)) dut (
        .CLK (CLK),
        .RST (RST),
        .CX  (CX),
        .CY  (CY),
        .CHAR(CHAR),
        .CWE (CWE),
        .CRDY(CRDY),
        .X   (X),
        .Y   (Y),
        .R   (R),
        .G   (G),
        .B   (B),
        .PWE (PWE),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] ref_row(input logic [7:0] code, input int r);
        logic [7:0] rows [8];
        rows = '{default: 8'h00};
        case (code)
            8'h2B: rows = '{8'h00, 8'h18, 8'h18, 8'h7E, 8'h18, 8'h18, 8'h00, 8'h00};
            8'h41: rows = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
            8'h48: rows = '{8'h66, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00};
            8'h49: rows = '{8'h3C, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h3C, 8'h00};
            8'h4F: rows = '{8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00};
            default: ;
        endcase
        return rows[r];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e_now, obs, want);
        end
    endtask

    // One clock edge of the reference: pop when the renderer is free, accept when not full,
    // then derive the pixel (if any) from the edge offset since the pop: 9 edges per row.
    task automatic model_edge(input logic cwe, input ref_cmd_t c);
        int         k, r, col;
        logic [7:0] row_bits;
        bit         pre_full;
        e_now++;
        pre_full = (cmd_q.size() == DEPTH);
        if (act && (e_now - pop_edge) >= 73) act = 0;
        if (!act && cmd_q.size() > 0) begin
            cur      = cmd_q.pop_front();
            act      = 1;
            pop_edge = e_now;
        end
        if (cwe && !pre_full) cmd_q.push_back(c);
        k       = e_now - pop_edge;
        exp_pwe = 1'b0;
        if (act && k >= 1 && k <= 71 && ((k - 1) % 9) < 8) begin
            r        = (k - 1) / 9;
            col      = (k - 1) % 9;
            row_bits = ref_row(cur.ch, r);
            exp_pwe  = 1'b1;
            exp_x    = 8'(cur.cx * 8 + col);
            exp_y    = 8'(cur.cy * 8 + r);
            exp_rgb  = row_bits[7 - col] ? FG : BG;
        end
        exp_busy = (cmd_q.size() != 0) || (act && k < 72);
        exp_crdy = (cmd_q.size() != DEPTH);
    endtask

    task automatic check_outputs();
        check("pwe",  PWE,       exp_pwe);
        check("crdy", CRDY,      exp_crdy);
        check("busy", BUSY,      exp_busy);
        check("x",    X,         exp_x);
        check("y",    Y,         exp_y);
        check("rgb",  {R, G, B}, exp_rgb);
        if (PWE) begin
            pwe_cnt++;
            if (low_run >= 2) begin
                glyph_cnt++;
                start_q.push_back(e_now);
            end
            low_run = 0;
        end else begin
            low_run++;
        end
    endtask

    task automatic step(input logic cwe, input logic [4:0] cx, input logic [3:0] cy, input logic [7:0] ch);
        @(negedge CLK);
        CWE  = cwe;
        CX   = cx;
        CY   = cy;
        CHAR = ch;
        @(posedge CLK);
        model_edge(cwe, {ch, cy, cx});
        #1;
        check_outputs();
    endtask

    task automatic drain();
        int guard = 0;
        while (((cmd_q.size() != 0) || (act && (e_now - pop_edge) < 72)) && guard < 2000) begin
            step(1'b0, 5'd0, 4'd0, 8'h00);
            guard++;
        end
        step(1'b0, 5'd0, 4'd0, 8'h00);
        check("drain_busy", BUSY, 0);
    endtask

    task automatic clear_counts();
        pwe_cnt   = 0;
        glyph_cnt = 0;
        start_q.delete();
    endtask

    function automatic logic [7:0] pick_char();
        logic [7:0] known [6];
        known = '{8'h20, 8'h2B, 8'h41, 8'h48, 8'h49, 8'h4F};
        case ($urandom_range(0, 3))
            0:       return 8'h80 | 8'($urandom_range(0, 127));
            1:       return 8'($urandom_range(0, 255));
            default: return known[$urandom_range(0, 5)];
        endcase
    endfunction

    initial begin
        logic [7:0] bp_chars [6];
        int         guard;
        bp_chars = '{8'h41, 8'h48, 8'h49, 8'h4F, 8'h2B, 8'h20};

        RST = 1'b1; CWE = 1'b0; CX = '0; CY = '0; CHAR = '0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_pwe",  PWE,       0);
        check("rst_crdy", CRDY,      1);
        check("rst_busy", BUSY,      0);
        check("rst_x",    X,         0);
        check("rst_y",    Y,         0);
        check("rst_rgb",  {R, G, B}, 0);
        @(negedge CLK);
        RST = 1'b0;

        // blank cell
        clear_counts();
        step(1'b1, 5'd3, 4'd2, 8'h20);
        drain();
        check("space_pwe_count", pwe_cnt,   64);
        check("space_glyphs",    glyph_cnt, 1);

        // glyph content at the far corner
        clear_counts();
        step(1'b1, 5'd31, 4'd15, 8'h49);
        drain();
        check("glyph_pwe_count", pwe_cnt, 64);

        // backpressure: six back-to-back writes, the last one dropped
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 5'(i + 8), 4'(i), bp_chars[i]);
            if (i == 4) check("bp_crdy_low_after_5th", CRDY, 0);
        end
        drain();
        check("bp_pwe_count", pwe_cnt,   320);
        check("bp_glyphs",    glyph_cnt, 5);

        // high codes render as background
        clear_counts();
        step(1'b1, 5'd7, 4'd9, 8'hC9);
        drain();
        check("high_pwe_count", pwe_cnt, 64);

        // reset during row 3 with commands queued
        step(1'b1, 5'd1, 4'd1, 8'h41);
        step(1'b1, 5'd2, 4'd2, 8'h48);
        step(1'b1, 5'd3, 4'd3, 8'h49);
        guard = 0;
        while (!(act && (e_now - pop_edge) >= 30) && guard < 200) begin
            step(1'b0, 5'd0, 4'd0, 8'h00);
            guard++;
        end
        #2;
        RST = 1'b1;
        #1;
        check("midrst_pwe",  PWE,       0);
        check("midrst_crdy", CRDY,      1);
        check("midrst_busy", BUSY,      0);
        check("midrst_x",    X,         0);
        check("midrst_y",    Y,         0);
        check("midrst_rgb",  {R, G, B}, 0);
        cmd_q.delete();
        act = 0; exp_pwe = 0; exp_busy = 0; exp_crdy = 1;
        exp_x = 0; exp_y = 0; exp_rgb = 0; low_run = 2;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        clear_counts();
        repeat (150) step(1'b0, 5'd0, 4'd0, 8'h00);
        check("midrst_no_pwe", pwe_cnt, 0);

        // push in the same cycle that IDLE pops the last entry
        clear_counts();
        step(1'b1, 5'd4, 4'd4, 8'h41);
        step(1'b1, 5'd5, 4'd5, 8'h4F);
        guard = 0;
        while ((e_now + 1) < (pop_edge + 73) && guard < 200) begin
            step(1'b0, 5'd0, 4'd0, 8'h00);
            guard++;
        end
        step(1'b1, 5'd6, 4'd6, 8'h2B);
        drain();
        check("pp_glyphs", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("pp_gap_ab", start_q[1] - start_q[0], 73);
            check("pp_gap_bc", start_q[2] - start_q[1], 73);
        end

        // randomized command stream
        clear_counts();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                step(1'b1, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), pick_char());
            else
                step(1'b0, 5'd0, 4'd0, 8'h00);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
